// File: rtl/butterfly_pipe_if.sv
// Stream interface for butterfly_pipe: operand/mode input channel and even/odd result channel,
// each with its own valid/ready pair.
interface butterfly_pipe_if #(
  parameter int unsigned WIDTH = 12
);
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_w;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_even;
  logic [WIDTH-1:0] out_odd;

  // Master issues operands and consumes results; slave is the butterfly.
  modport master (
    output in_valid, in_mode, in_a, in_b, in_w, out_ready,
    input  in_ready, out_valid, out_even, out_odd
  );

  modport slave (
    input  in_valid, in_mode, in_a, in_b, in_w, out_ready,
    output in_ready, out_valid, out_even, out_odd
  );
endinterface

// File: rtl/butterfly_pipe.sv
// Pipelined mod-Q NTT butterfly (CT forward / GS inverse), lockstep valid/ready pipeline.
// Define BUTTERFLY_DIV2_EN to scale both GS outputs by 2^-1 mod Q in the last stage.
module butterfly_pipe #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned Q     = 3329,
  parameter int unsigned LAT   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  butterfly_pipe_if.slave bus_io
);
  localparam int unsigned      PW          = 2 * WIDTH;
  localparam logic [WIDTH-1:0] QW          = WIDTH'(Q);
  localparam logic [PW-1:0]    QP          = PW'(Q);
  localparam longint unsigned  BarrettLong = (64'd1 << PW) / 64'(Q);
  localparam logic [PW-1:0]    BarrettM    = PW'(BarrettLong);

  if (LAT != 3) begin : g_lat_check
    $error("butterfly_pipe supports LAT = 3 only");
  end

  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH:0] t;
    t = {1'b0, x} + {1'b0, y};
    if (t >= {1'b0, QW}) t = t - {1'b0, QW};
    return t[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH:0] t;
    t = {1'b0, x} - {1'b0, y};
    if (t[WIDTH]) t = t + {1'b0, QW};
    return t[WIDTH-1:0];
  endfunction

`ifdef BUTTERFLY_DIV2_EN
  // x * 2^-1 mod Q for odd Q: odd values borrow one Q so the shift is exact.
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] t;
    t = x[0] ? ({1'b0, x} + {1'b0, QW}) : {1'b0, x};
    return WIDTH'(t >> 1);
  endfunction
`endif

  // Stage 1: captured operands
  logic             s1_valid_q, s1_valid_d;
  logic             s1_mode_q, s1_mode_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_w_q, s1_w_d;
  // Stage 2: full-width product; x is a (CT) or the reduced sum a+b (GS)
  logic             s2_valid_q, s2_valid_d;
  logic             s2_mode_q, s2_mode_d;
  logic [WIDTH-1:0] s2_x_q, s2_x_d;
  logic [PW-1:0]    s2_prod_q, s2_prod_d;
  // Stage 3: product reduced to [0,Q-1]
  logic             s3_valid_q, s3_valid_d;
  logic             s3_mode_q, s3_mode_d;
  logic [WIDTH-1:0] s3_x_q, s3_x_d;
  logic [WIDTH-1:0] s3_r_q, s3_r_d;
  // Output stage
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_even_q, out_even_d;
  logic [WIDTH-1:0] out_odd_q, out_odd_d;

  logic             stall;
  logic [WIDTH-1:0] s1_sum, s1_dif;
  logic [PW-1:0]    bar_qhat;
  logic [WIDTH:0]   bar_r;

  assign stall            = out_valid_q && !bus_io.out_ready;
  assign bus_io.in_ready  = !stall;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_even  = out_even_q;
  assign bus_io.out_odd   = out_odd_q;

  always_comb begin
    s1_valid_d = bus_io.in_valid;
    s1_mode_d  = bus_io.in_mode;
    s1_a_d     = bus_io.in_a;
    s1_b_d     = bus_io.in_b;
    s1_w_d     = bus_io.in_w;

    // GS multiplies the difference, CT multiplies b; both by w.
    s1_sum     = mod_add(s1_a_q, s1_b_q);
    s1_dif     = mod_sub(s1_a_q, s1_b_q);
    s2_valid_d = s1_valid_q;
    s2_mode_d  = s1_mode_q;
    s2_x_d     = s1_mode_q ? s1_sum : s1_a_q;
    s2_prod_d  = {{WIDTH{1'b0}}, (s1_mode_q ? s1_dif : s1_b_q)} * {{WIDTH{1'b0}}, s1_w_q};

    // Barrett with k = 2*WIDTH: quotient estimate is low by at most one, so r < 2Q.
    bar_qhat   = PW'(({{PW{1'b0}}, s2_prod_q} * {{PW{1'b0}}, BarrettM}) >> PW);
    bar_r      = (WIDTH+1)'(s2_prod_q - bar_qhat * QP);
    if (bar_r >= {1'b0, QW}) bar_r = bar_r - {1'b0, QW};
    s3_valid_d = s2_valid_q;
    s3_mode_d  = s2_mode_q;
    s3_x_d     = s2_x_q;
    s3_r_d     = bar_r[WIDTH-1:0];

    out_valid_d = s3_valid_q;
    if (s3_mode_q) begin
`ifdef BUTTERFLY_DIV2_EN
      out_even_d = half_mod(s3_x_q);
      out_odd_d  = half_mod(s3_r_q);
`else
      out_even_d = s3_x_q;
      out_odd_d  = s3_r_q;
`endif
    end else begin
      out_even_d = mod_add(s3_x_q, s3_r_q);
      out_odd_d  = mod_sub(s3_x_q, s3_r_q);
    end
  end

  // Lockstep pipeline: every stage advances together unless the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_w_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_mode_q   <= 1'b0;
      s2_x_q      <= '0;
      s2_prod_q   <= '0;
      s3_valid_q  <= 1'b0;
      s3_mode_q   <= 1'b0;
      s3_x_q      <= '0;
      s3_r_q      <= '0;
      out_valid_q <= 1'b0;
      out_even_q  <= '0;
      out_odd_q   <= '0;
    end else if (!stall) begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_w_q      <= s1_w_d;
      s2_valid_q  <= s2_valid_d;
      s2_mode_q   <= s2_mode_d;
      s2_x_q      <= s2_x_d;
      s2_prod_q   <= s2_prod_d;
      s3_valid_q  <= s3_valid_d;
      s3_mode_q   <= s3_mode_d;
      s3_x_q      <= s3_x_d;
      s3_r_q      <= s3_r_d;
      out_valid_q <= out_valid_d;
      out_even_q  <= out_even_d;
      out_odd_q   <= out_odd_d;
    end
  end
endmodule

// File: tb/tb_butterfly_pipe.sv
// Scoreboard bench for butterfly_pipe: directed vectors, stall/throughput, async reset,
// and randomized traffic with random backpressure against an arithmetic reference model.
module tb_butterfly_pipe;
  localparam int W = 12;
  localparam int Q = 3329;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  butterfly_pipe_if #(.WIDTH(W)) bus ();

  butterfly_pipe #(.WIDTH(W), .Q(Q), .LAT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int acc_cyc = 0;
  logic [2*W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input bit gs, input int a, input int b, input int w);
    int e, o, t;
    if (!gs) begin
      t = (b * w) % Q;
      e = (a + t) % Q;
      o = (a - t + Q) % Q;
    end else begin
      e = (a + b) % Q;
      o = (((a - b + Q) % Q) * w) % Q;
`ifdef BUTTERFLY_DIV2_EN
      e = (e * ((Q + 1) / 2)) % Q;
      o = (o * ((Q + 1) / 2)) % Q;
`endif
    end
    return {e[W-1:0], o[W-1:0]};
  endfunction

  function automatic int pick_op();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return 0;
    if (r == 1) return Q - 1;
    return int'($urandom_range(0, Q - 1));
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge that accepted the beat.
  task automatic send(input bit gs, input int a, input int b, input int w,
                      input logic [2*W-1:0] e);
    int n;
    bit done;
    n = 0;
    done = 0;
    bus.in_valid = 1'b1;
    bus.in_mode  = gs;
    bus.in_a     = a[W-1:0];
    bus.in_b     = b[W-1:0];
    bus.in_w     = w[W-1:0];
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(e);
        acc_cyc = cyc;
        done = 1;
      end else if (++n > 200) begin
        chk("in_ready_timeout", 0, 1);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: a result transfers on the coming edge when valid && ready at the falling edge.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        chk("out_even", int'(bus.out_even), int'(exp_q[0][2*W-1:W]));
        chk("out_odd", int'(bus.out_odd), int'(exp_q[0][W-1:0]));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, first, last, stale;
    bit rand_done;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_w      = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("init_in_ready", int'(bus.in_ready), 1);
    chk("init_out_valid", int'(bus.out_valid), 0);
    chk("init_out_even", int'(bus.out_even), 0);
    chk("init_out_odd", int'(bus.out_odd), 0);
    @(posedge clk);
    #1;

    // Latency of a lone beat
    send(0, 2, 3, 1, {12'd5, 12'd3328});
    bus.in_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.out_valid && n < 10);
    chk("latency", n, 3);

    // Directed vectors with literal expectations
    send(0, 3328, 1, 1, {12'd0, 12'd3327});
    send(0, 100, 10, 100, {12'd1100, 12'd2429});
    send(0, 3328, 3328, 3328, {12'd0, 12'd3327});
`ifdef BUTTERFLY_DIV2_EN
    send(1, 5, 3, 17, {12'd4, 12'd17});
    send(1, 3, 5, 1, {12'd4, 12'd3328});
`else
    send(1, 5, 3, 17, {12'd8, 12'd34});
    send(1, 3, 5, 1, {12'd8, 12'd3327});
`endif
    drain();

    // Eight alternating-mode beats with a 4-cycle output stall mid-stream
    first = 0;
    last  = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          int a, b, w;
          a = pick_op();
          b = pick_op();
          w = pick_op();
          send(bit'(i % 2), a, b, w, model(bit'(i % 2), a, b, w));
          if (i == 0) first = acc_cyc;
        end
        last = acc_cyc;
        bus.in_valid = 1'b0;
      end
      begin
        int k;
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!bus.out_valid && k < 50);
        chk("stall_setup_valid", int'(bus.out_valid), 1);
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("stall_in_ready", int'(bus.in_ready), 0);
          chk("stall_out_valid", int'(bus.out_valid), 1);
          chk("stall_even_held", int'(bus.out_even), int'(exp_q[0][2*W-1:W]));
          chk("stall_odd_held", int'(bus.out_odd), int'(exp_q[0][W-1:0]));
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    chk("stream_accept_span", last - first, 11);
    drain();
    @(posedge clk);
    #1;

    // Randomized traffic with random input gaps and random backpressure
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          int a, b, w;
          bit gs;
          gs = bit'($urandom_range(0, 1));
          a  = pick_op();
          b  = pick_op();
          w  = pick_op();
          send(gs, a, b, w, model(gs, a, b, w));
          if ($urandom_range(0, 3) == 0) idle();
        end
        bus.in_valid = 1'b0;
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          if (!rand_done) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    @(posedge clk);
    #1;

    // Asynchronous reset with two beats in flight
    send(0, 7, 9, 11, model(0, 7, 9, 11));
    send(1, 20, 4, 5, model(1, 20, 4, 5));
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_out_valid", int'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_out_even", int'(bus.out_even), 0);
    chk("mid_rst_out_odd", int'(bus.out_odd), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(bus.in_ready), 1);
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    chk("no_stale_beat", stale, 0);
    @(posedge clk);
    #1;

    // Recovery after reset
    send(0, 100, 10, 100, {12'd1100, 12'd2429});
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
